// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - AXI-Lite mapped 8N1 UART receiver with status, data and baud registers
// Oversamples rx_pin through a 2-flop synchronizer; one-entry holding register with overrun/framing flags.
module uart_rx #(
  parameter int unsigned WIDTH_DA     = 32,
  parameter int unsigned WIDTH_AD     = 32,
  parameter logic [31:0] BAUD_DEFAULT = 32'h1B8
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESET,
  input  logic [WIDTH_AD-1:0] S_AXI_AWADDR,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [WIDTH_DA-1:0] S_AXI_WDATA,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [WIDTH_AD-1:0] S_AXI_ARADDR,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [WIDTH_DA-1:0] S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY,
  input  logic                rx_pin
);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  localparam logic [7:0]  ADDR_STATE = 8'h00;
  localparam logic [7:0]  ADDR_RX    = 8'h04;
  localparam logic [7:0]  ADDR_BAUD  = 8'h08;
  localparam logic [15:0] BAUD_RST   = BAUD_DEFAULT[15:0];

  w_state_t            r_wstate, w_wstate_nxt;
  rx_state_t           r_rxstate, w_rxstate_nxt;
  logic [7:0]          r_awaddr;
  logic [15:0]         r_baud;
  logic                r_rx_valid, r_overrun, r_frame_err;
  logic [7:0]          r_rx_data, r_shift;
  logic [1:0]          r_sync;
  logic [15:0]         r_cnt;
  logic [2:0]          r_bit_cnt;
  logic                r_rvalid;
  logic [WIDTH_DA-1:0] r_rdata;
  logic [WIDTH_DA-1:0] w_rd_mux;
  logic w_rx_s, w_aw_hs, w_w_hs, w_ar_hs, w_rx_rd, w_bit_evt;
  logic w_cnt_clr, w_bit_clr, w_shift_en, w_deliver, w_ferr_set, w_ovr_set;
  logic w_w1c_ovr, w_w1c_ferr;
  logic w_unused;

  assign w_unused = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA};

  assign S_AXI_AWREADY = (r_wstate == W_IDLE);
  assign S_AXI_WREADY  = (r_wstate == W_DATA);
  assign S_AXI_BVALID  = (r_wstate == W_RESP);
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ~r_rvalid;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;

  assign w_aw_hs    = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_w_hs     = S_AXI_WVALID & S_AXI_WREADY;
  assign w_ar_hs    = S_AXI_ARVALID & S_AXI_ARREADY;
  assign w_rx_rd    = w_ar_hs & (S_AXI_ARADDR[7:0] == ADDR_RX);
  assign w_w1c_ovr  = w_w_hs & (r_awaddr == ADDR_STATE) & S_AXI_WDATA[1];
  assign w_w1c_ferr = w_w_hs & (r_awaddr == ADDR_STATE) & S_AXI_WDATA[2];
  assign w_ovr_set  = w_deliver & r_rx_valid & ~w_rx_rd;
  assign w_rx_s     = r_sync[1];
  assign w_bit_evt  = (r_cnt >= r_baud);

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) r_wstate <= W_IDLE;
    else              r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (S_AXI_AWVALID) w_wstate_nxt = W_DATA;
      W_DATA:  if (S_AXI_WVALID)  w_wstate_nxt = W_RESP;
      W_RESP:  if (S_AXI_BREADY)  w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_awaddr <= '0;
      r_baud   <= BAUD_RST;
    end else begin
      if (w_aw_hs) r_awaddr <= S_AXI_AWADDR[7:0];
      if (w_w_hs && (r_awaddr == ADDR_BAUD)) r_baud <= S_AXI_WDATA[15:0];
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (S_AXI_ARADDR[7:0])
      ADDR_STATE: w_rd_mux[2:0]  = {r_frame_err, r_overrun, r_rx_valid};
      ADDR_RX:    w_rd_mux[7:0]  = r_rx_data;
      ADDR_BAUD:  w_rd_mux[15:0] = r_baud;
      default:    ;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_mux;
    end else if (S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  // Sets take priority over a same-cycle W1C of the same flag.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_rx_valid  <= 1'b0;
      r_rx_data   <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_deliver && !w_ovr_set) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (w_rx_rd) begin
        r_rx_valid <= 1'b0;
      end
      if (w_ovr_set)       r_overrun <= 1'b1;
      else if (w_w1c_ovr)  r_overrun <= 1'b0;
      if (w_ferr_set)      r_frame_err <= 1'b1;
      else if (w_w1c_ferr) r_frame_err <= 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_sync    <= 2'b11;
      r_rxstate <= RX_IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_sync    <= {r_sync[0], rx_pin};
      r_rxstate <= w_rxstate_nxt;
      r_cnt     <= w_cnt_clr ? 16'd0 : r_cnt + 16'd1;
      if (w_bit_clr)       r_bit_cnt <= '0;
      else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_shift_en) r_shift[r_bit_cnt] <= w_rx_s;
    end
  end

  always_comb begin
    w_rxstate_nxt = r_rxstate;
    w_cnt_clr     = 1'b0;
    w_bit_clr     = 1'b0;
    w_shift_en    = 1'b0;
    w_deliver     = 1'b0;
    w_ferr_set    = 1'b0;
    case (r_rxstate)
      RX_IDLE: begin
        if (!w_rx_s) begin
          w_cnt_clr     = 1'b1;
          w_rxstate_nxt = RX_START;
        end
      end
      RX_START: begin
        if (r_cnt == (r_baud >> 1)) begin
          if (!w_rx_s) begin
            w_cnt_clr     = 1'b1;
            w_bit_clr     = 1'b1;
            w_rxstate_nxt = RX_DATA;
          end else begin
            w_rxstate_nxt = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (w_bit_evt) begin
          w_shift_en = 1'b1;
          w_cnt_clr  = 1'b1;
          if (r_bit_cnt == 3'd7) w_rxstate_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_bit_evt) begin
          w_cnt_clr = 1'b1;
          if (w_rx_s) begin
            w_deliver     = 1'b1;
            w_rxstate_nxt = RX_IDLE;
          end else begin
            w_ferr_set    = 1'b1;
            w_rxstate_nxt = RX_WAIT;
          end
        end
      end
      // Hold off until the line returns high so a stuck-low line cannot retrigger.
      RX_WAIT: if (w_rx_s) w_rxstate_nxt = RX_IDLE;
      default: w_rxstate_nxt = RX_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx against an abstract receive-register model
module tb_uart_rx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] S_AXI_AWADDR = '0, S_AXI_WDATA = '0, S_AXI_ARADDR = '0;
  logic        S_AXI_AWVALID = 1'b0, S_AXI_WVALID = 1'b0, S_AXI_ARVALID = 1'b0;
  logic        S_AXI_BREADY = 1'b1, S_AXI_RREADY = 1'b1;
  logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic [31:0] S_AXI_RDATA;
  logic        rx_pin = 1'b1;

  always #5 clk = ~clk;

  uart_rx dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY), .rx_pin(rx_pin)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  addr;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Register-level view of the peripheral: one holding slot plus sticky flags.
  bit          m_valid, m_ovr, m_ferr;
  logic [7:0]  m_data;
  logic [15:0] m_baud;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_valid = 0; m_ovr = 0; m_ferr = 0; m_data = 8'h00; m_baud = 16'h01B8;
  endtask

  task automatic m_deliver(input logic [7:0] b);
    if (m_valid) m_ovr = 1;
    else begin
      m_data  = b;
      m_valid = 1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && S_AXI_RVALID && S_AXI_RREADY) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rdata: got %h expected no read outstanding", S_AXI_RDATA);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("rdata@%02h", e.addr), S_AXI_RDATA, e.data);
        chk("rresp", {30'd0, S_AXI_RRESP}, 32'd0);
      end
    end
  end

  task automatic rd(input logic [7:0] a);
    exp_t e;
    int   n;
    e.addr = a;
    case (a)
      8'h00: e.data = {29'd0, m_ferr, m_ovr, m_valid};
      8'h04: begin e.data = {24'd0, m_data}; m_valid = 0; end
      8'h08: e.data = {16'd0, m_baud};
      default: e.data = 32'd0;
    endcase
    exp_q.push_back(e);
    @(negedge clk);
    S_AXI_ARADDR  = {24'd0, a};
    S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 100) begin @(negedge clk); n++; end
    if (!S_AXI_ARREADY) begin
      total++; bad++;
      $display("FAIL ar_timeout: got arready=0 expected 1");
    end
    @(posedge clk);
    #1 S_AXI_ARVALID = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    S_AXI_AWADDR = {24'd0, a}; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA  = d;          S_AXI_WVALID  = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 S_AXI_AWVALID = 1'b0;
    n = 0;
    while (!S_AXI_WREADY && n < 100) begin @(negedge clk); n++; end
    chk("wready", {31'd0, S_AXI_WREADY}, 32'd1);
    @(posedge clk);
    #1 S_AXI_WVALID = 1'b0;
    @(negedge clk);
    chk("bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
    chk("bresp", {30'd0, S_AXI_BRESP}, 32'd0);
    @(posedge clk);
    if (a == 8'h00) begin
      if (d[1]) m_ovr = 0;
      if (d[2]) m_ferr = 0;
    end else if (a == 8'h08) begin
      m_baud = d[15:0];
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_stop);
    int n;
    n = int'(m_baud) + 1;
    @(negedge clk);
    rx_pin = 1'b0;
    repeat (n) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (n) @(negedge clk);
    end
    if (bad_stop) begin
      rx_pin = 1'b0;
      repeat (3 * n) @(negedge clk);
    end
    rx_pin = 1'b1;
    repeat (n + 4) @(negedge clk);
    if (bad_stop) m_ferr = 1;
    else          m_deliver(b);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, {31'd0, S_AXI_AWREADY}, 32'd1);
    chk({tag, "_arready"}, {31'd0, S_AXI_ARREADY}, 32'd1);
    chk({tag, "_wready"},  {31'd0, S_AXI_WREADY},  32'd0);
    chk({tag, "_bvalid"},  {31'd0, S_AXI_BVALID},  32'd0);
    chk({tag, "_rvalid"},  {31'd0, S_AXI_RVALID},  32'd0);
    chk({tag, "_rdata"},   S_AXI_RDATA,            32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    m_reset();
    repeat (3) @(negedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    rd(8'h00);
    rd(8'h08);

    wr(8'h08, 32'd15);
    send_frame(8'hA5, 0);
    rd(8'h00); rd(8'h04); rd(8'h00);

    send_frame(8'h3C, 0);
    send_frame(8'hF0, 0);
    rd(8'h00); rd(8'h04);
    wr(8'h00, 32'h2);
    rd(8'h00);

    send_frame(8'h55, 1);
    rd(8'h00);
    wr(8'h00, 32'h4);
    send_frame(8'h81, 0);
    rd(8'h00); rd(8'h04);

    @(negedge clk);
    rx_pin = 1'b0;
    repeat (4) @(negedge clk);
    rx_pin = 1'b1;
    repeat (40) @(negedge clk);
    rd(8'h00);
    send_frame(8'h7E, 0);
    rd(8'h04); rd(8'h0C);

    // AR handshake lands on the edge where the stop bit of 0x22 is sampled:
    // 4 + (baud>>1) + 9*(baud+1) = 155 clocks after the falling edge at baud 15.
    send_frame(8'h11, 0);
    drain();
    fork
      send_frame(8'h22, 0);
      begin
        @(negedge clk);
        repeat (154) @(posedge clk);
        rd(8'h04);
      end
    join
    rd(8'h00); rd(8'h04); rd(8'h00);

    wr(8'h08, 32'hABCD0007);
    rd(8'h08);
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 2) == 0) wr(8'h08, $urandom_range(3, 30));
      b = 8'($urandom);
      send_frame(b, $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 1) begin rd(8'h00); rd(8'h04); end
      if ($urandom_range(0, 2) == 0) begin wr(8'h00, 32'h6); rd(8'h00); end
    end
    rd(8'h00);

    wr(8'h08, 32'd15);
    drain();
    @(negedge clk);
    rx_pin = 1'b0;
    repeat (5 * 16 + 8) @(negedge clk);
    rst = 1'b1;
    #1 chk_reset_outputs("midframe");
    rx_pin = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rd(8'h08); rd(8'h00);
    send_frame(8'hC3, 0);
    rd(8'h00); rd(8'h04); rd(8'h00);

    drain();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive peripheral on the AXI memory-mapped bus, the receive-side counterpart of the core's UART transmitter. It oversamples `rx_pin`, deframes 8N1 characters (start 0, 8 data bits LSB first, stop 1) into a single-entry holding register, and exposes status, data and baud-divisor registers to the core. It is uncached, and it uses the same register layout and baud-divisor convention as the transmitter.

## Interface
- `WIDTH_DA`, 32, data bus width.
- `WIDTH_AD`, 32, address bus width. Only `[7:0]` is decoded.
- `BAUD_DEFAULT`, 32'h1B8, reset value of REG_BAUD. This is 115200 baud.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `S_AXI_ACLK` in 1: clock.
- `S_AXI_ARESET` in 1: asynchronous, active-high reset.
- `S_AXI_AWADDR` in WIDTH_AD: write address.
- `S_AXI_AWVALID` in 1: write address valid.
- `S_AXI_AWREADY` out 1: high only in W_Idle.
- `S_AXI_WDATA` in WIDTH_DA: write data.
- `S_AXI_WVALID` in 1: write data valid.
- `S_AXI_WREADY` out 1: high only in W_Data.
- `S_AXI_BRESP` out 2: constant 2'b00.
- `S_AXI_BVALID` out 1: write response valid.
- `S_AXI_BREADY` in 1: write response accept.
- `S_AXI_ARADDR` in WIDTH_AD: read address.
- `S_AXI_ARVALID` in 1: read address valid.
- `S_AXI_ARREADY` out 1: high when `S_AXI_RVALID` is 0.
- `S_AXI_RDATA` out WIDTH_DA: read data, registered.
- `S_AXI_RRESP` out 2: constant 2'b00.
- `S_AXI_RVALID` out 1: read data valid.
- `S_AXI_RREADY` in 1: read data accept.
- `rx_pin` in 1: asynchronous serial input. The line idles high.

## Operation
- **REG_STATE 0x0**
  - bit0 `rx_valid` (RO).
  - bit1 `overrun` (W1C).
  - bit2 `frame_err` (W1C).
  - Other bits read 0.
- **REG_RX 0x4**
  - `[7:0]` holds the received byte; upper bits read 0.
  - An accepted read clears `rx_valid`.
  - Writes are ignored.
- **REG_BAUD 0x8**
  - `[15:0]` = cycles per bit minus 1. Upper bits are ignored on write and read as 0.
  - Writes take effect immediately, including mid-frame.
- **Unmapped addresses:** reads return 0; writes are ignored. All responses are OKAY.
- **Write FSM**
  - W_Idle: on AW handshake, latch the address → W_Data.
  - W_Data: on W handshake, perform the write, set BVALID → W_Resp.
  - W_Resp: on BREADY, clear BVALID → W_Idle.
- **Read path**
  - On AR handshake, capture RDATA from the current register values and set RVALID.
  - RVALID and RDATA are held until RREADY.
- **Synchronizer:** `rx_pin` passes through 2 flops to give `rx_s`. All receive logic uses `rx_s` only.
- **Counters:** `cnt` is 16 bits; `baud` = REG_BAUD[15:0]. Bit-compare events use `cnt >= baud`, so lowering the baud value mid-frame cannot stall the counter.
- **RX FSM**
  - RX_Idle: when `rx_s == 0`, clear `cnt` → RX_Start.
  - RX_Start: when `cnt == baud>>1`:
    - if `rx_s == 0`, clear `cnt` and `bit_cnt` → RX_Data;
    - otherwise the low was a glitch → RX_Idle.
  - RX_Data: on each bit-compare event, shift `rx_s` into `shift[bit_cnt]` and clear `cnt`. After bit 7 → RX_Stop.
  - RX_Stop: on the bit-compare event, sample `rx_s`:
    - `rx_s == 1`: deliver the byte → RX_Idle.
    - `rx_s == 0`: set `frame_err`, discard the byte → RX_Wait.
  - RX_Wait: when `rx_s == 1` → RX_Idle. This prevents the line staying low from retriggering a start.
- **Deliver**
  - If `rx_valid` is 1 and is not being cleared this cycle: set `overrun`, discard the new byte, and keep the old one.
  - Otherwise: load `rx_data` from `shift` and set `rx_valid`.
- **Simultaneous events**
  - A REG_RX read accepted in the same cycle as deliver: RDATA returns the old byte, the new byte is loaded, `rx_valid` stays 1, and there is no overrun.
  - A W1C write in the same cycle as a set of the same bit: the set wins.
- **Reset** is asynchronous and valid at any time, including mid-frame. It returns every FSM to idle and discards any partial byte.

## Timing
- **Reset values**
  - `S_AXI_AWREADY` = 1, `S_AXI_ARREADY` = 1.
  - `S_AXI_WREADY`, `S_AXI_BVALID`, `S_AXI_RVALID` = 0.
  - `S_AXI_RDATA`, `S_AXI_BRESP`, `S_AXI_RRESP` = 0.
  - REG_STATE = 0, `rx_data` = 0, REG_BAUD = `BAUD_DEFAULT`.
- **Read latency:** RVALID rises the cycle after the AR handshake.
- **Write latency:** the register update and BVALID both occur the cycle after the W handshake.
- **Sampling:** with N = baud+1 cycles per bit, the start bit is sampled about N/2 cycles after the falling edge, then each data bit and the stop bit one bit period later, each at mid-bit.
- **Latency to `rx_valid`:** `rx_valid` rises 2 + 1 + (baud>>1) + 9·N cycles (±1) after the `rx_pin` falling edge.
- **Minimum baud:** supported REG_BAUD ≥ 3; behaviour below 3 is unspecified.

## Test plan
- **Clean byte:** REG_BAUD = 15, drive 0xA5 at 16 cycles/bit.
  - REG_STATE reads 0x1, REG_RX reads 0x000000A5, then REG_STATE reads 0x0.
- **Back-to-back overrun:** receive 0x3C then 0xF0 without reading.
  - REG_STATE reads 0x3 and REG_RX reads 0x3C.
  - After writing 0x2 to REG_STATE, it reads 0x0.
- **Framing error:** drive 0x55 with the stop bit low for 3 bits, then release the line.
  - REG_STATE reads 0x4 and no byte is delivered.
  - The following byte 0x81 is received correctly.
- **Glitch:** drive `rx_pin` low for 4 cycles at baud = 15.
  - RX FSM returns to idle and REG_STATE stays 0x0.
  - A subsequent 0x7E is received correctly.
- **Read/deliver collision:** with 0x11 held, issue a REG_RX read timed so its AR handshake coincides with delivery of 0x22.
  - RDATA = 0x11, REG_STATE = 0x1, next REG_RX read = 0x22, no overrun.
- **Reset mid-frame and default baud:**
  - Assert `S_AXI_ARESET` during data bit 4: all outputs return to reset values and REG_BAUD reads 0x1B8.
  - A full byte at 441 cycles/bit is then received correctly.
